// File: rtl/frame_pkg.sv
// frame_pkg: constants shared by the serial downlink transmit and receive
// blocks. It holds the 36-bit frame layout, the error codes, the receiver
// state enum and the receive-side frame checker.
package frame_pkg;

    localparam int          FRAME_BITS = 36;
    localparam logic [5:0]  PREAMBLE   = 6'b101010;
    localparam logic [3:0]  TRAILER    = 4'b0101;

    // Field bit positions within the frame (bit 35 is sent first).
    localparam int PRE_LSB   = 30;
    localparam int PAIR_MSB  = 29;
    localparam int PAIR_LSB  = 22;
    localparam int MODE1_POS = 28;
    localparam int MODE0_POS = 26;
    localparam int TYPE1_POS = 24;
    localparam int TYPE0_POS = 22;
    localparam int DATA_MSB  = 21;
    localparam int DATA_LSB  = 6;
    localparam int PAR_N_POS = 5;
    localparam int PAR_POS   = 4;
    localparam int TRL_MSB   = 3;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_PRE  = 3'd1;
    localparam logic [2:0] ERR_PAIR = 3'd2;
    localparam logic [2:0] ERR_PAR  = 3'd3;
    localparam logic [2:0] ERR_TRL  = 3'd4;

    typedef enum logic [1:0] {IDLE, HALF, SHIFT, CHECK} rx_state_e;

    // Returns the lowest-numbered failing check, or ERR_NONE.
    function automatic logic [2:0] frame_check(input logic [FRAME_BITS-1:0] f);
        logic       pair_ok;
        logic [2:0] code;
        pair_ok = 1'b1;
        // Each (~x, x) pair must differ.
        for (int i = PAIR_LSB; i < PAIR_MSB; i += 2) begin
            if (f[i+1] == f[i]) pair_ok = 1'b0;
        end
        if (f[FRAME_BITS-1:PRE_LSB] != PREAMBLE)
            code = ERR_PRE;
        else if (!pair_ok)
            code = ERR_PAIR;
        else if ((f[PAR_POS] != ^f[DATA_MSB:DATA_LSB]) || (f[PAR_N_POS] == f[PAR_POS]))
            code = ERR_PAR;
        else if (f[TRL_MSB:0] != TRAILER)
            code = ERR_TRL;
        else
            code = ERR_NONE;
        return code;
    endfunction

endpackage

// File: rtl/frame_rx_decoder_din_sync.sv
// din_sync: line input conditioning for the downlink receiver.
//   clk_i, rst_i : clock, synchronous active-high reset
//   din_i        : asynchronous line input
//   din_s_o      : synchronized line level (2-flop synchronizer)
//   fall_o       : one-cycle pulse when din_s_o falls from 1 to 0
module din_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic din_s_o,
    output logic fall_o
);

    logic s1_q, s2_q, dly_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            s1_q  <= din_i;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    assign din_s_o = s2_q;
    assign fall_o  = dly_q & ~s2_q;

endmodule

// File: rtl/frame_rx_decoder.sv
// frame_rx_decoder: receive side of the serial downlink. It hunts for the
// bit-35/34 falling edge, samples each bit at mid-period and validates the
// 36-bit frame. It then strobes frame_valid_o (updating mode/type/data) or
// frame_err_o (with err_code_o).
//   clk_i, rst_i   : clock, synchronous active-high reset
//   en_i           : receiver enable; low aborts and holds IDLE
//   din_i          : asynchronous line input
//   mode_o, type_o : decoded fields of the last valid frame
//   data_o         : payload of the last valid frame
//   frame_valid_o  : one-cycle pass strobe
//   frame_err_o    : one-cycle fail strobe
//   err_code_o     : 1 preamble, 2 pair, 3 parity, 4 trailer; 0 after pass
//   busy_o         : high from start detect until the strobe
module frame_rx_decoder
    import frame_pkg::*;
#(
    parameter int BIT_PERIOD = 200000,
    parameter int CNT_W      = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        din_i,
    output logic [1:0]  mode_o,
    output logic [1:0]  type_o,
    output logic [15:0] data_o,
    output logic        frame_valid_o,
    output logic        frame_err_o,
    output logic [2:0]  err_code_o,
    output logic        busy_o
);

    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BIT_PERIOD/2 - 1);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BIT_PERIOD - 1);

    logic din_s, fall;

    din_sync u_din_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .din_i   (din_i),
        .din_s_o (din_s),
        .fall_o  (fall)
    );

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       bit_q;
    logic [34:0]      sr_q;
    logic [1:0]       mode_q, type_q;
    logic [15:0]      data_q;
    logic             valid_q, err_q, busy_q;
    logic [2:0]       err_code_q;

    // sr_q is preloaded with the implicit bit-35 '1' and collects bits 34..1.
    // Bit 0 is taken straight from the synchronizer so that the check result
    // can be registered on the bit-0 sample and strobe during CHECK.
    logic [FRAME_BITS-1:0] frame_d;
    logic [2:0]            err_d;

    assign frame_d = {sr_q, din_s};
    assign err_d   = frame_check(frame_d);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sr_q       <= '0;
            mode_q     <= '0;
            type_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (!en_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fall) begin
                            state_q <= HALF;
                            cnt_q   <= HALF_LD;
                            sr_q    <= 35'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                    HALF: begin
                        if (cnt_q == '0) begin
                            sr_q    <= {sr_q[33:0], din_s};
                            cnt_q   <= FULL_LD;
                            bit_q   <= 6'd33;
                            state_q <= SHIFT;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    SHIFT: begin
                        if (cnt_q == '0) begin
                            sr_q  <= {sr_q[33:0], din_s};
                            cnt_q <= FULL_LD;
                            if (bit_q == 6'd0) begin
                                state_q <= CHECK;
                                if (err_d == ERR_NONE) begin
                                    valid_q    <= 1'b1;
                                    mode_q     <= {frame_d[MODE1_POS], frame_d[MODE0_POS]};
                                    type_q     <= {frame_d[TYPE1_POS], frame_d[TYPE0_POS]};
                                    data_q     <= frame_d[DATA_MSB:DATA_LSB];
                                    err_code_q <= ERR_NONE;
                                end else begin
                                    err_q      <= 1'b1;
                                    err_code_q <= err_d;
                                end
                            end else begin
                                bit_q <= bit_q - 6'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    CHECK: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mode_o        = mode_q;
    assign type_o        = type_q;
    assign data_o        = data_q;
    assign frame_valid_o = valid_q;
    assign frame_err_o   = err_q;
    assign err_code_o    = err_code_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_frame_rx_decoder.sv
// Scoreboard bench for frame_rx_decoder with BIT_PERIOD = 16.
module tb_frame_rx_decoder;

    localparam int BP = 16;

    logic        clk = 1'b0;
    logic        rst, en, din;
    logic [1:0]  mode, typ;
    logic [15:0] data;
    logic        fv, fe, busy;
    logic [2:0]  ec;

    frame_rx_decoder #(.BIT_PERIOD(BP), .CNT_W(20)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .din_i         (din),
        .mode_o        (mode),
        .type_o        (typ),
        .data_o        (data),
        .frame_valid_o (fv),
        .frame_err_o   (fe),
        .err_code_o    (ec),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  m;
        logic [1:0]  t;
        logic [15:0] d;
        logic [2:0]  c;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  last_m = '0, last_t = '0;
    logic [15:0] last_d = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic [1:0] m, input logic [1:0] t, input logic [15:0] d);
        return {6'b101010, ~m[1], m[1], ~m[0], m[0], ~t[1], t[1], ~t[0], t[0],
                d, ~(^d), ^d, 4'b0101};
    endfunction

    // Expected outcome of the next frame; a failing frame keeps the last good fields.
    task automatic push(input logic v, input logic [1:0] m, input logic [1:0] t,
                        input logic [15:0] d, input logic [2:0] c);
        exp_t x;
        if (v) begin
            last_m = m; last_t = t; last_d = d;
        end
        x.v = v; x.m = last_m; x.t = last_t; x.d = last_d; x.c = c;
        sb.push_back(x);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mode"}, 32'(mode), 0);
        chk({tag, "_type"}, 32'(typ), 0);
        chk({tag, "_data"}, 32'(data), 0);
        chk({tag, "_fv"}, 32'(fv), 0);
        chk({tag, "_fe"}, 32'(fe), 0);
        chk({tag, "_ec"}, 32'(ec), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Drives one frame, MSB first. drop_at/rst_at name a bit at whose start
    // en is dropped / rst is pulsed (-1 = never). A reset abandons the frame.
    task automatic send(input logic [35:0] f, input int drop_at, input int rst_at);
        for (int i = 35; i >= 0; i--) begin
            din = f[i];
            for (int c = 0; c < BP; c++) begin
                @(negedge clk);
                if (i == drop_at && c == 0) en = 1'b0;
                if (i == drop_at && c == 1) chk("en_drop_busy", 32'(busy), 0);
                if (i == rst_at && c == 0) begin
                    chk("busy_before_rst", 32'(busy), 1);
                    rst = 1'b1;
                end
                if (i == rst_at && c == 1) begin
                    rst = 1'b0;
                    chk_zero("mid_rst");
                    last_m = '0; last_t = '0; last_d = '0;
                    return;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare every strobe against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (fv || fe)) begin
            chk("strobe_excl", 32'(fv & fe), 0);
            chk("busy_at_strobe", 32'(busy), 1);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'({fv, fe}), 0);
            end else begin
                e = sb.pop_front();
                chk("valid", 32'(fv), 32'(e.v));
                chk("err", 32'(fe), 32'(!e.v));
                chk("mode", 32'(mode), 32'(e.m));
                chk("type", 32'(typ), 32'(e.t));
                chk("data", 32'(data), 32'(e.d));
                chk("err_code", 32'(ec), 32'(e.c));
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] f;
        rst = 1'b1; en = 1'b1; din = 1'b0;
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        idle(5);

        // Basic valid frame.
        push(1'b1, 2'b11, 2'b01, 16'hA5C3, 3'd0);
        send(mk(2'b11, 2'b01, 16'hA5C3), -1, -1);
        idle(20);
        chk("ec_after_pass", 32'(ec), 0);

        // Pair mismatch on ~m0.
        f = mk(2'b11, 2'b01, 16'hA5C3);
        f[27] = ~f[27];
        push(1'b0, 0, 0, 0, 3'd2);
        send(f, -1, -1);
        idle(20);
        chk("ec_hold", 32'(ec), 2);

        // Parity bit forced to 0.
        f = mk(2'b00, 2'b10, 16'h0001);
        f[4] = 1'b0;
        push(1'b0, 0, 0, 0, 3'd3);
        send(f, -1, -1);
        idle(20);

        // Preamble also corrupted: lowest code wins.
        f[32] = ~f[32];
        push(1'b0, 0, 0, 0, 3'd1);
        send(f, -1, -1);
        idle(20);

        // Trailer error.
        f = mk(2'b01, 2'b01, 16'hBEEF);
        f[0] = 1'b0;
        push(1'b0, 0, 0, 0, 3'd4);
        send(f, -1, -1);
        idle(20);

        // Back-to-back frames, no idle gap.
        push(1'b1, 2'b01, 2'b10, 16'h1234, 3'd0);
        push(1'b1, 2'b00, 2'b11, 16'hFFFE, 3'd0);
        send(mk(2'b01, 2'b10, 16'h1234), -1, -1);
        send(mk(2'b00, 2'b11, 16'hFFFE), -1, -1);
        idle(20);

        // Enable dropped mid-frame; next frame decodes.
        send(mk(2'b10, 2'b00, 16'h0F0F), 20, -1);
        en = 1'b1;
        idle(20);
        push(1'b1, 2'b10, 2'b00, 16'h3C3C, 3'd0);
        send(mk(2'b10, 2'b00, 16'h3C3C), -1, -1);
        idle(20);

        // Reset mid-frame; later frame decodes.
        send(mk(2'b01, 2'b11, 16'h5555), -1, 10);
        idle(20);
        push(1'b1, 2'b10, 2'b10, 16'hAAAA, 3'd0);
        send(mk(2'b10, 2'b10, 16'hAAAA), -1, -1);
        idle(20);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_rx_decoder.md
# frame_rx_decoder

Receive-side counterpart of the Zybo-to-drone serial downlink. It samples the one-wire bit stream produced by the transmit block at the fixed bit period and reassembles the 36-bit frame. It validates preamble, complementary mode/type pairs, parity pair and trailer, then presents `mode`, `type` and the 16-bit payload with a one-cycle valid or error strobe. It sits on the drone board between the line input pin and the command/telemetry logic.

## Interface
- `BIT_PERIOD`, default 200000: clk cycles per line bit; must match the transmitter's 20'h30D40. Minimum 4.
- `CNT_W`, default 20: width of the bit-period counter; must hold `BIT_PERIOD-1`.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  receiver enable; low aborts any frame in progress and holds the block in IDLE.
- `din`  in  1  asynchronous line input; the line idles at 0 after transmitter reset.
- `mode`  out  2  decoded mode of the last valid frame.
- `type`  out  2  decoded type of the last valid frame.
- `data`  out  16  payload of the last valid frame.
- `frame_valid`  out  1  one-cycle strobe; the frame passed all checks.
- `frame_err`  out  1  one-cycle strobe; the frame failed a check.
- `err_code`  out  3  1 = preamble, 2 = pair mismatch, 3 = parity, 4 = trailer. Held until the next strobe.
- `busy`  out  1  high from start detect until the strobe.

## Operation
- **Frame layout**, bit 35 sent first:
  - [35:30] = 101010
  - [29:22] = ~m1,m1,~m0,m0,~t1,t1,~t0,t0
  - [21:6] = data[15:0], MSB first
  - [5] = ~^data
  - [4] = ^data
  - [3:0] = 0101
- **Input conditioning:** `din` passes through a 2-flop synchronizer, then a registered copy is kept for edge detection.
- **Start detect:** the block hunts for the falling edge between bit 35 (1) and bit 34 (0). This edge exists in every frame, even when the line sits at 1 after the previous trailer. Bit 35 is recorded as 1 implicitly.
- **States:**
  - IDLE: waits for a synchronized falling edge with `en`=1, then goes to HALF.
  - HALF: the period counter is loaded with `BIT_PERIOD/2-1`. At 0 the block samples bit 34, reloads `BIT_PERIOD-1` and goes to SHIFT.
  - SHIFT: the block samples when the counter reaches 0 and reloads. The bit counter runs 33 down to 0. After the bit-0 sample it goes to CHECK.
  - CHECK: single cycle. The block evaluates all checks, strobes, then returns to IDLE.
- **Check priority:** the lowest error code wins. A failed check sets `frame_err`=1 and `err_code`. It leaves `mode`/`type`/`data` unchanged.
- **Pass:** `mode`/`type`/`data` update in the same cycle as `frame_valid`, and `err_code` clears to 0.
- **Pair rule:** each pair must be complementary. The true value is the second bit of the pair.
- **Parity rule:** bit 4 must equal ^data and bit 5 must equal ~bit 4.
- **Edges while busy:** line edges during HALF/SHIFT/CHECK are ignored. There is no re-synchronization mid-frame.
- **`en` low:** in any state, the block enters IDLE next cycle, clears `busy`, and produces no strobe.
- **`rst`:** all outputs go to 0, state goes to IDLE and the counters clear. This applies mid-frame too.

## Timing
- The decision point is the mid-bit sample. The edge-to-sample offset is `BIT_PERIOD/2` plus a fixed 3-cycle synchronizer/edge latency.
- `frame_valid`/`frame_err` assert exactly 1 cycle after the bit-0 sample, i.e. in the CHECK state.
- Start of frame to strobe: about 34.5×`BIT_PERIOD` + 4 cycles after the bit-35/34 edge on the pin.
- The block can detect a new falling edge on the cycle after CHECK. No holdoff is required.
- Strobes never coincide. Both strobes are low in every cycle except CHECK.
- `busy` rises the cycle after edge detect and falls in the cycle after CHECK.

## Structure
- Shared package `frame_pkg`:
  - `PREAMBLE`=6'b101010, `TRAILER`=4'b0101, `FRAME_BITS`=36
  - field bit positions
  - error code constants
  - the state enum (IDLE, HALF, SHIFT, CHECK)
- The transmit block uses the same constants.
- One sub-module, `din_sync`: a 2-flop synchronizer plus a registered delay. It outputs `din_s` and `fall` (a one-cycle falling-edge pulse).
- The top level holds the FSM, period counter, bit counter, 35-bit shift register and checker.

## Test plan
All scenarios use `BIT_PERIOD`=16.
- Valid frame, mode=2'b11, type=2'b01, data=16'hA5C3 (parity 0) → one `frame_valid`, outputs 3/1/A5C3, `err_code`=0, `frame_err` never high.
- Same frame with bit 27 (~m0) flipped → `frame_err`, `err_code`=2, outputs keep their previous values.
- data=16'h0001 with bit 4 sent as 0 → `frame_err`, `err_code`=3. With the preamble also corrupted at bit 32 → `err_code`=1 (priority).
- Two back-to-back frames with no idle gap, line staying at 1 after the first trailer → two `frame_valid` strobes, the second with the new payload.
- `en` dropped at bit 20 → no strobe, `busy` low next cycle. A frame sent after `en` returns high decodes correctly.
- `rst` pulsed at bit 10 → all outputs 0 next cycle. A later full frame decodes correctly.
